// File: rtl/rstdown_oxbridge.sv
// Graceful teardown sequencer: quiesces the CPU, drains the OX Core, then asserts reset holds
// in reverse bring-up order; on re-enable it pulses the bring-up controller's reset.
module rstdown_oxbridge #(
  parameter int DELAY_CPU2OXC  = 31,
  parameter int DELAY_OXC2RXD  = 31,
  parameter int DELAY_RXD2MAC  = 1023,
  parameter int DELAY_MAC2MII  = 31,
  parameter int WIDTH_DLY      = 10,
  parameter int TIMEOUT        = 4095,
  parameter int WIDTH_TO       = 12,
  parameter int RESTART_CYCLES = 4,
  parameter bit HOLD_MII       = 1'b1
) (
  input  logic clk,
  input  logic rst_,
  input  logic req_down,
  input  logic req_up,
  input  logic cpu_quiesce_ack,
  input  logic oxc_drain_done,
  output logic cpu_quiesce_req,
  output logic oxc_drain_req,
  output logic hold_cpu_,
  output logic hold_oxc_,
  output logic hold_rxd_,
  output logic hold_mac_,
  output logic hold_mii_,
  output logic seq_restart_,
  output logic busy,
  output logic down_done,
  output logic timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_QCPU, S_RCPU, S_DOXC, S_ROXC, S_RRXD, S_RMAC, S_RMII, S_DOWN, S_RST
  } state_t;

  localparam logic [WIDTH_DLY-1:0] LAST_CPU2OXC = WIDTH_DLY'(DELAY_CPU2OXC);
  localparam logic [WIDTH_DLY-1:0] LAST_OXC2RXD = WIDTH_DLY'(DELAY_OXC2RXD);
  localparam logic [WIDTH_DLY-1:0] LAST_RXD2MAC = WIDTH_DLY'(DELAY_RXD2MAC);
  localparam logic [WIDTH_DLY-1:0] LAST_MAC2MII = WIDTH_DLY'(DELAY_MAC2MII);
  localparam logic [WIDTH_DLY-1:0] LAST_RESTART = WIDTH_DLY'(RESTART_CYCLES - 1);
  localparam logic [WIDTH_TO-1:0]  LAST_TO      = WIDTH_TO'(TIMEOUT - 1);

  state_t               state;
  logic [WIDTH_DLY-1:0] dly_cnt;
  logic [WIDTH_TO-1:0]  to_cnt;

  // Outputs are written alongside the state so each state drives them from its first cycle;
  // both counters free-run and are cleared on every transition.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state           <= S_IDLE;
      dly_cnt         <= '0;
      to_cnt          <= '0;
      cpu_quiesce_req <= 1'b0;
      oxc_drain_req   <= 1'b0;
      hold_cpu_       <= 1'b1;
      hold_oxc_       <= 1'b1;
      hold_rxd_       <= 1'b1;
      hold_mac_       <= 1'b1;
      hold_mii_       <= 1'b1;
      seq_restart_    <= 1'b1;
      busy            <= 1'b0;
      down_done       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      dly_cnt <= dly_cnt + WIDTH_DLY'(1);
      to_cnt  <= to_cnt + WIDTH_TO'(1);
      case (state)
        S_IDLE: begin
          if (req_down) begin
            state           <= S_QCPU;
            cpu_quiesce_req <= 1'b1;
            busy            <= 1'b1;
            timeout_err     <= 1'b0;
            dly_cnt         <= '0;
            to_cnt          <= '0;
          end
        end
        S_QCPU: begin
          // An ack arriving on the final timeout cycle wins and does not flag an error.
          if (cpu_quiesce_ack || to_cnt == LAST_TO) begin
            state     <= S_RCPU;
            hold_cpu_ <= 1'b0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
            if (!cpu_quiesce_ack) timeout_err <= 1'b1;
          end
        end
        S_RCPU: begin
          if (dly_cnt == LAST_CPU2OXC) begin
            state         <= S_DOXC;
            oxc_drain_req <= 1'b1;
            dly_cnt       <= '0;
            to_cnt        <= '0;
          end
        end
        S_DOXC: begin
          if (oxc_drain_done || to_cnt == LAST_TO) begin
            state     <= S_ROXC;
            hold_oxc_ <= 1'b0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
            if (!oxc_drain_done) timeout_err <= 1'b1;
          end
        end
        S_ROXC: begin
          if (dly_cnt == LAST_OXC2RXD) begin
            state     <= S_RRXD;
            hold_rxd_ <= 1'b0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
          end
        end
        S_RRXD: begin
          if (dly_cnt == LAST_RXD2MAC) begin
            state     <= S_RMAC;
            hold_mac_ <= 1'b0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
          end
        end
        S_RMAC: begin
          if (dly_cnt == LAST_MAC2MII) begin
            dly_cnt <= '0;
            to_cnt  <= '0;
            if (HOLD_MII) begin
              state     <= S_RMII;
              hold_mii_ <= 1'b0;
            end else begin
              state     <= S_DOWN;
              down_done <= 1'b1;
            end
          end
        end
        S_RMII: begin
          state     <= S_DOWN;
          down_done <= 1'b1;
          dly_cnt   <= '0;
          to_cnt    <= '0;
        end
        S_DOWN: begin
          if (req_up) begin
            state        <= S_RST;
            down_done    <= 1'b0;
            seq_restart_ <= 1'b0;
            dly_cnt      <= '0;
            to_cnt       <= '0;
          end
        end
        S_RST: begin
          // Holds release in the same cycle the bring-up controller leaves reset.
          if (dly_cnt == LAST_RESTART) begin
            state           <= S_IDLE;
            seq_restart_    <= 1'b1;
            hold_cpu_       <= 1'b1;
            hold_oxc_       <= 1'b1;
            hold_rxd_       <= 1'b1;
            hold_mac_       <= 1'b1;
            hold_mii_       <= 1'b1;
            cpu_quiesce_req <= 1'b0;
            oxc_drain_req   <= 1'b0;
            busy            <= 1'b0;
            dly_cnt         <= '0;
            to_cnt          <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
